// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC core among N_REQ requesters, with an ID tag pipe matched to core latency.
// Optional build macro CORDIC_ARB_STATS_EN adds saturating per-requester accept counters and a busy-cycle counter.
module cordic_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = $clog2(N_REQ),
   parameter int BIT_WIDTH = 32,
   parameter int LATENCY   = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*BIT_WIDTH-1:0]    req_angle,
   input  logic [N_REQ*BIT_WIDTH-1:0]    req_x,
   input  logic [N_REQ*BIT_WIDTH-1:0]    req_y,
   input  logic                          drain,
   output logic                          idle,
   output logic                          core_start,
   output logic signed [BIT_WIDTH-1:0]   core_angle,
   output logic signed [BIT_WIDTH-1:0]   core_x,
   output logic signed [BIT_WIDTH-1:0]   core_y,
   input  logic                          core_done,
   input  logic signed [BIT_WIDTH-1:0]   core_out_x,
   input  logic signed [BIT_WIDTH-1:0]   core_out_y,
   output logic                          rsp_valid,
   output logic [ID_W-1:0]               rsp_id,
   output logic signed [BIT_WIDTH-1:0]   rsp_x,
   output logic signed [BIT_WIDTH-1:0]   rsp_y,
   output logic                          tag_err
`ifdef CORDIC_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]           stat_issued,
   output logic [31:0]                   stat_busy
`endif
);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] win_id;
   logic [ID_W:0]   scan_idx;
   logic            found;
   logic            accept;
   logic [ID_W-1:0] core_id_p0;
   logic [LATENCY-1:0] tag_vld_p1;
   logic [ID_W-1:0]    tag_id_p1 [LATENCY];
   logic               head_vld;
   logic [ID_W-1:0]    head_id;

   // Arbitration: scan from rr_ptr with wrap, first pending requester wins
   always_comb begin
      found    = 1'b0;
      win_id   = '0;
      scan_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (scan_idx >= (ID_W+1)'(N_REQ))
            scan_idx = scan_idx - (ID_W+1)'(N_REQ);
         if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
            found  = 1'b1;
            win_id = scan_idx[ID_W-1:0];
         end
      end
   end

   // Grants are suppressed while reset is held so the outputs read all-zero
   assign accept = found & ~drain & reset;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++)
         req_ready[i] = accept && (win_id == ID_W'(i));
   end

   // Issue stage p0: drive the core the cycle after the grant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= '0;
         core_start <= 1'b0;
         core_id_p0 <= '0;
         core_angle <= '0;
         core_x     <= '0;
         core_y     <= '0;
      end else begin
         core_start <= accept;
         if (accept) begin
            rr_ptr     <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
            core_id_p0 <= win_id;
            core_angle <= req_angle[win_id*BIT_WIDTH +: BIT_WIDTH];
            core_x     <= req_x[win_id*BIT_WIDTH +: BIT_WIDTH];
            core_y     <= req_y[win_id*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   // Tag stage p1: shadow of the core pipeline, last entry lines up with core_done
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld_p1 <= '0;
         for (int i = 0; i < LATENCY; i++)
            tag_id_p1[i] <= '0;
      end else begin
         tag_vld_p1   <= {tag_vld_p1[LATENCY-2:0], core_start};
         tag_id_p1[0] <= core_id_p0;
         for (int i = 1; i < LATENCY; i++)
            tag_id_p1[i] <= tag_id_p1[i-1];
      end
   end

   assign head_vld = tag_vld_p1[LATENCY-1];
   assign head_id  = tag_id_p1[LATENCY-1];

   // Response stage p2: a done without a matching tag (or vice versa) drops the result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_x     <= '0;
         rsp_y     <= '0;
         tag_err   <= 1'b0;
      end else begin
         rsp_valid <= core_done & head_vld;
         if (core_done & head_vld) begin
            rsp_id <= head_id;
            rsp_x  <= core_out_x;
            rsp_y  <= core_out_y;
         end
         if (core_done != head_vld)
            tag_err <= 1'b1;
      end
   end

   assign idle = ~|tag_vld_p1 & ~core_start & ~rsp_valid & ~|req_ready;

`ifdef CORDIC_ARB_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_issued <= '0;
         stat_busy   <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (req_ready[i])
               stat_issued[i*16 +: 16] <= sat_inc16(stat_issued[i*16 +: 16]);
         if (|tag_vld_p1)
            stat_busy <= sat_inc32(stat_busy);
      end
   end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: ideal-rotator core stand-in, queue-based reference model, vector table and corner sequences.
module tb_cordic_arbiter;
   localparam int  N  = 4;
   localparam int  IW = 2;
   localparam int  BW = 32;
   localparam int  L  = 32;
   localparam real KG = 1.6467602581210654;
   localparam real TWO_PI = 6.283185307179586;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*BW-1:0] req_angle = '0;
   logic [N*BW-1:0] req_x = '0;
   logic [N*BW-1:0] req_y = '0;
   logic            drain = 1'b0;
   logic            idle;
   logic            core_start;
   logic [BW-1:0]   core_angle, core_x, core_y;
   logic            core_done;
   logic [BW-1:0]   core_out_x, core_out_y;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [BW-1:0]   rsp_x, rsp_y;
   logic            tag_err;
`ifdef CORDIC_ARB_STATS_EN
   logic [N*16-1:0] stat_issued;
   logic [31:0]     stat_busy;
`endif

   cordic_arbiter #(.N_REQ(N), .ID_W(IW), .BIT_WIDTH(BW), .LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_angle(req_angle), .req_x(req_x), .req_y(req_y),
      .drain(drain), .idle(idle),
      .core_start(core_start), .core_angle(core_angle), .core_x(core_x), .core_y(core_y),
      .core_done(core_done), .core_out_x(core_out_x), .core_out_y(core_out_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .tag_err(tag_err)
`ifdef CORDIC_ARB_STATS_EN
      , .stat_issued(stat_issued), .stat_busy(stat_busy)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Ideal rotator with CORDIC gain; angle full scale 2^32 = 2*pi
   function automatic logic [31:0] core_fx(input logic [31:0] a, input logic [31:0] x, input logic [31:0] y);
      real ang, r;
      ang = $itor($signed(a)) * TWO_PI / 4294967296.0;
      r   = KG * ($itor($signed(x)) * $cos(ang) - $itor($signed(y)) * $sin(ang));
      return 32'($rtoi(r));
   endfunction

   function automatic logic [31:0] core_fy(input logic [31:0] a, input logic [31:0] x, input logic [31:0] y);
      real ang, r;
      ang = $itor($signed(a)) * TWO_PI / 4294967296.0;
      r   = KG * ($itor($signed(y)) * $cos(ang) + $itor($signed(x)) * $sin(ang));
      return 32'($rtoi(r));
   endfunction

   // Core stand-in: fixed LATENCY pipe, reset by the same system reset
   logic [L-1:0]  cv;
   logic [BW-1:0] cx [L];
   logic [BW-1:0] cy [L];
   logic          force_done = 1'b0;
   always @(posedge clk or negedge reset) begin
      if (!reset) cv <= '0;
      else begin
         cv    <= {cv[L-2:0], core_start};
         cx[0] <= core_fx(core_angle, core_x, core_y);
         cy[0] <= core_fy(core_angle, core_x, core_y);
         for (int i = 1; i < L; i++) begin
            cx[i] <= cx[i-1];
            cy[i] <= cy[i-1];
         end
      end
   end
   assign core_done  = cv[L-1] | force_done;
   assign core_out_x = cx[L-1];
   assign core_out_y = cy[L-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: pointer, expected-response queue, response log
   typedef struct {int id; logic [31:0] x; logic [31:0] y; int due;} exp_t;
   typedef struct {int c; int id;} log_t;
   exp_t q[$];
   log_t rsp_log[$];
   int   mptr = 0;
   int   m_w;
   logic [N-1:0] m_er;
   exp_t e;
   log_t lg;
   logic err_exp = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         mptr = 0;
         q.delete();
         chk("rst_ready", req_ready, 0);
         chk("rst_core_start", core_start, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_x", rsp_x, 0);
         chk("rst_tag_err", tag_err, 0);
         chk("rst_idle", idle, 1);
      end else begin
         m_er = '0;
         m_w  = -1;
         if (!drain)
            for (int i = 0; i < N; i++)
               if (m_w < 0 && req_valid[(mptr + i) % N]) m_w = (mptr + i) % N;
         if (m_w >= 0) m_er[m_w] = 1'b1;
         chk("grant", req_ready, m_er);
         chk("idle", idle, (q.size() == 0 && m_w < 0) ? 1 : 0);
         chk("tag_err", tag_err, err_exp);
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_x", rsp_x, q[0].x);
            chk("rsp_y", rsp_y, q[0].y);
            lg.c  = cyc;
            lg.id = q[0].id;
            rsp_log.push_back(lg);
            void'(q.pop_front());
         end else begin
            chk("rsp_valid_quiet", rsp_valid, 0);
         end
         if (m_w >= 0) begin
            e.id  = m_w;
            e.x   = core_fx(req_angle[m_w*BW +: BW], req_x[m_w*BW +: BW], req_y[m_w*BW +: BW]);
            e.y   = core_fy(req_angle[m_w*BW +: BW], req_x[m_w*BW +: BW], req_y[m_w*BW +: BW]);
            e.due = cyc + L + 2;
            q.push_back(e);
            mptr = (m_w + 1) % N;
         end
      end
   end

   function automatic logic [31:0] small_val();
      return $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
   endfunction

   task automatic set_data();
      for (int i = 0; i < N; i++) begin
         req_angle[i*BW +: BW] = $urandom;
         req_x[i*BW +: BW]     = small_val();
         req_y[i*BW +: BW]     = small_val();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      err_exp = 1'b0; req_valid = '0; drain = 1'b0; force_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   typedef struct {logic [N-1:0] v; logic d; logic [N-1:0] rdy;} vec_t;
   vec_t vt[13];

   initial begin
      int kx, t0, tl, n0;
      bit got;
      longint dx, dy;
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
      kx = 0; t0 = 0; tl = 0; n0 = 0; got = 0; dx = 0; dy = 0;
   end

   initial begin
      int kx, t0, tl, n0;
      bit got;
      longint dx, dy;
      // Vectors applied from a fresh reset (pointer at 0)
      vt[0]  = '{4'b0001, 1'b0, 4'b0001};
      vt[1]  = '{4'b1111, 1'b0, 4'b0010};
      vt[2]  = '{4'b1111, 1'b0, 4'b0100};
      vt[3]  = '{4'b1111, 1'b0, 4'b1000};
      vt[4]  = '{4'b1111, 1'b0, 4'b0001};
      vt[5]  = '{4'b0000, 1'b0, 4'b0000};
      vt[6]  = '{4'b1001, 1'b0, 4'b1000};
      vt[7]  = '{4'b0110, 1'b1, 4'b0000};
      vt[8]  = '{4'b0110, 1'b0, 4'b0010};
      vt[9]  = '{4'b1100, 1'b0, 4'b0100};
      vt[10] = '{4'b0010, 1'b0, 4'b0010};
      vt[11] = '{4'b0011, 1'b0, 4'b0001};
      vt[12] = '{4'b0011, 1'b0, 4'b0010};

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Single op, unit-scaled x at angle 0
      kx = $rtoi(2147483647.0 / KG);
      @(posedge clk);
      #1 req_valid = 4'b0001;
      req_angle[0 +: BW] = '0; req_x[0 +: BW] = 32'(kx); req_y[0 +: BW] = '0;
      @(negedge clk);
      chk("t1_ready", req_ready, 4'b0001);
      t0 = cyc;
      @(posedge clk);
      #1 req_valid = '0;
      got = 0;
      for (int k = 0; k < L + 10 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1;
            chk("t1_latency", cyc - t0, L + 2);
            chk("t1_id", rsp_id, 0);
            dx = longint'($signed(rsp_x)) - 64'sd2147483647;
            dy = longint'($signed(rsp_y));
            chk("t1_x_near_fullscale", (dx <= 4 && dx >= -4) ? 1 : 0, 1);
            chk("t1_y_near_zero", (dy <= 4 && dy >= -4) ? 1 : 0, 1);
         end
      end
      if (!got) chk("t1_timeout", 0, 1);

      // Vector table
      do_reset();
      for (int r = 0; r < 13; r++) begin
         @(posedge clk);
         #1 req_valid = vt[r].v; drain = vt[r].d; set_data();
         @(negedge clk);
         chk($sformatf("vec%0d_ready", r), req_ready, vt[r].rdy);
      end
      @(posedge clk);
      #1 req_valid = '0; drain = 1'b0;
      repeat (L + 5) @(negedge clk);

      // All four requesting for eight cycles
      do_reset();
      n0 = rsp_log.size();
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1 req_valid = 4'b1111; set_data();
         @(negedge clk);
         chk($sformatf("t2_grant%0d", k), req_ready, 64'(1) << (k % 4));
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (L + 4) @(negedge clk);
      chk("t2_rsp_count", rsp_log.size() - n0, 8);
      if (rsp_log.size() >= n0 + 8)
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_rsp_id%0d", k), rsp_log[n0+k].id, k % 4);
            chk($sformatf("t2_rsp_gap%0d", k), rsp_log[n0+k].c - rsp_log[n0].c, k);
         end

      // Drain with five ops in flight
      do_reset();
      n0 = rsp_log.size();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 req_valid = 4'b1111; set_data();
         @(negedge clk);
         tl = cyc;
      end
      @(posedge clk);
      #1 drain = 1'b1;
      @(negedge clk);
      chk("t4_no_grant", req_ready, 0);
      for (int k = 0; k < L + 8; k++) begin
         if (cyc == tl + L + 2) begin
            chk("t4_idle_low_last_rsp", idle, 0);
            chk("t4_last_rsp_valid", rsp_valid, 1);
         end
         if (cyc == tl + L + 3) begin
            chk("t4_idle_rise", idle, 1);
            break;
         end
         @(negedge clk);
      end
      chk("t4_rsp_count", rsp_log.size() - n0, 5);
      @(posedge clk);
      #1 drain = 1'b0; req_valid = '0;

      // Randomized traffic with occasional drain
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #1 req_valid = N'($urandom);
         drain = ($urandom_range(0, 7) == 0);
         set_data();
      end
      @(posedge clk);
      #1 req_valid = '0; drain = 1'b0;
      repeat (L + 4) @(negedge clk);
      chk("rand_final_idle", idle, 1);

      // Spurious core_done with an empty tag pipe
      @(posedge clk);
      #1 force_done = 1'b1;
      @(negedge clk);
      chk("t5_drop_rsp", rsp_valid, 0);
      @(posedge clk);
      #1 force_done = 1'b0; err_exp = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_sticky", tag_err, 1);
      chk("t5_no_rsp", rsp_valid, 0);
      do_reset();
      @(negedge clk);
      chk("t5_err_cleared", tag_err, 0);
      chk("t5_idle_after_reset", idle, 1);

      // Reset with three ops in flight from requester 1
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 req_valid = 4'b0010; set_data();
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(negedge clk);
`ifdef CORDIC_ARB_STATS_EN
      chk("t6_stat_issued1", stat_issued[31:16], 3);
      chk("t6_stat_issued0", stat_issued[15:0], 0);
      chk("t6_stat_busy_nonzero", (stat_busy != 0) ? 1 : 0, 1);
`endif
      n0 = rsp_log.size();
      do_reset();
      repeat (L + 6) @(negedge clk);
      chk("t6_flushed", rsp_log.size() - n0, 0);
`ifdef CORDIC_ARB_STATS_EN
      chk("t6_stat_cleared", stat_issued[31:16], 0);
`endif
      @(posedge clk);
      #1 req_valid = 4'b0001; set_data();
      @(posedge clk);
      #1 req_valid = '0;
      repeat (L + 4) @(negedge clk);
      chk("t6_new_op_done", rsp_log.size() - n0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
